cc_protocol_monitor: RTL and testbench

//  Synthesizable, parametrised protocol/score checker for the CC (Candy Crush) interface.

---
 rtl/cc_mon_pkg.sv | 25 ++
 rtl/cc_exp_fifo.sv | 49 ++++
 rtl/cc_protocol_monitor.sv | 142 ++++++++++++++
 tb/tb_cc_protocol_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_mon_pkg.sv
// Shared types for the CC protocol monitor: FSM states, sticky error codes,
// and the lowest-code-wins priority encoder.
package cc_mon_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, OUT, ERR} state_e;

    localparam logic [3:0] ERR_NONE      = 4'd0;
    localparam logic [3:0] ERR_RST_DATA  = 4'd1;
    localparam logic [3:0] ERR_TIMEOUT   = 4'd2;
    localparam logic [3:0] ERR_LONG      = 4'd3;
    localparam logic [3:0] ERR_SHORT     = 4'd4;
    localparam logic [3:0] ERR_IDLE_DATA = 4'd5;
    localparam logic [3:0] ERR_EARLY     = 4'd6;
    localparam logic [3:0] ERR_EMPTY     = 4'd7;
    localparam logic [3:0] ERR_MISMATCH  = 4'd8;

    // Scan from the highest code down so the lowest raised code is kept.
    function automatic logic [3:0] first_err(input logic [8:1] e);
        first_err = ERR_NONE;
        for (int i = 8; i >= 1; i--) begin
            if (e[i]) first_err = 4'(i);
        end
    endfunction

endpackage

// File: rtl/cc_exp_fifo.sv
// Expected-score FIFO. A push while full succeeds only when a pop
// happens in the same cycle, leaving the count unchanged.
module cc_exp_fifo #(
    parameter  int W     = 7,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cc_protocol_monitor.sv
// Snoops the CC handshake, measures in_valid_2-fall to out_valid latency,
// scores each output beat against the expected FIFO and latches the first error.
module cc_protocol_monitor
    import cc_mon_pkg::*;
#(
    parameter  int SCORE_W   = 7,
    parameter  int OUT_BEATS = 1,
    parameter  int MAX_LAT   = 500,
    parameter  int EXP_DEPTH = 16,
    parameter  int CNT_W     = 16,
    localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_1,
    input  logic               in_valid_2,
    input  logic               out_valid,
    input  logic [SCORE_W-1:0] out_score,
    input  logic               exp_valid,
    input  logic [SCORE_W-1:0] exp_score,
    output logic               exp_ready,
    output logic               err,
    output logic [3:0]         err_code,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [LAT_W-1:0]   last_lat
);

    localparam int BEAT_W = $clog2(OUT_BEATS + 1);
    localparam int AW     = $clog2(EXP_DEPTH);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d, last_lat_q, last_lat_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic               err_q, err_d;
    logic [3:0]         code_q, code_d, code_det;
    logic               first_q, iv2_q;
    logic [8:1]         e;
    logic               cmp, fifo_full;
    logic [SCORE_W-1:0] fifo_head;
    logic [AW:0]        fifo_cnt;
    logic               all_beats;

    cc_exp_fifo #(.W(SCORE_W), .DEPTH(EXP_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (exp_valid),
        .data_i  (exp_score),
        .pop_i   (cmp),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign all_beats = (beats_q == BEAT_W'(OUT_BEATS));
    // The beat that moves WAIT->OUT is beat 1 and is scored like the rest.
    assign cmp = out_valid && ((state_q == WAIT) || (state_q == OUT && !all_beats));

    always_comb begin
        e = '0;
        if (state_q != ERR) begin
            e[ERR_RST_DATA]  = first_q && (out_valid || out_score != '0);
            e[ERR_TIMEOUT]   = (state_q == WAIT) && !out_valid && (lat_q == LAT_W'(MAX_LAT));
            e[ERR_LONG]      = (state_q == OUT) && out_valid && all_beats;
            e[ERR_SHORT]     = (state_q == OUT) && !out_valid && !all_beats;
            e[ERR_IDLE_DATA] = !out_valid && (out_score != '0);
            e[ERR_EARLY]     = out_valid && (state_q == LOAD || in_valid_1 || in_valid_2);
            e[ERR_EMPTY]     = cmp && (fifo_cnt == '0);
            e[ERR_MISMATCH]  = cmp && (fifo_cnt != '0) && (fifo_head != out_score);
        end
        code_det = first_err(e);
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        beats_d    = beats_q;
        pass_d     = pass_q;
        last_lat_d = last_lat_q;
        err_d      = err_q;
        code_d     = code_q;
        case (state_q)
            IDLE: if (in_valid_1 || in_valid_2) state_d = LOAD;
            LOAD: if (iv2_q && !in_valid_2) begin
                state_d = WAIT;
                lat_d   = '0;
            end
            WAIT: if (out_valid) begin
                state_d    = OUT;
                beats_d    = BEAT_W'(1);
                last_lat_d = lat_q;
            end else if (lat_q != LAT_W'(MAX_LAT)) begin
                lat_d = lat_q + LAT_W'(1);
            end
            OUT: if (out_valid) begin
                if (!all_beats) beats_d = beats_q + BEAT_W'(1);
            end else if (all_beats) begin
                state_d = IDLE;
                if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
            end
            default: state_d = ERR;
        endcase
        // Any detected error pre-empts the normal transition, including a pass.
        if (code_det != ERR_NONE) begin
            state_d = ERR;
            pass_d  = pass_q;
            err_d   = 1'b1;
            code_d  = code_det;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            beats_q    <= '0;
            pass_q     <= '0;
            last_lat_q <= '0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            first_q    <= 1'b1;
            iv2_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            beats_q    <= beats_d;
            pass_q     <= pass_d;
            last_lat_q <= last_lat_d;
            err_q      <= err_d;
            code_q     <= code_d;
            first_q    <= 1'b0;
            iv2_q      <= in_valid_2;
        end
    end

    assign exp_ready = !fifo_full;
    assign err       = err_q;
    assign err_code  = code_q;
    assign pass_cnt  = pass_q;
    assign last_lat  = last_lat_q;

endmodule

// File: tb/tb_cc_protocol_monitor.sv
// Directed bench: instance A (OUT_BEATS=1) and B (OUT_BEATS=3) share stimulus,
// only the selected one is out of reset. Expected pass/error events go into
// per-instance queues; monitors pop them whenever pass_cnt steps or err rises.
module tb_cc_protocol_monitor;

    typedef struct packed {
        logic [15:0] pass;
        logic [8:0]  lat;
        logic        err;
        logic [3:0]  code;
    } ev_t;

    logic clk, rst_n, sel;
    logic in_valid_1, in_valid_2, out_valid, exp_valid;
    logic [6:0] out_score, exp_score;
    logic rst_a, rst_b;
    logic exp_ready_a, err_a, exp_ready_b, err_b;
    logic [3:0] code_a, code_b;
    logic [15:0] pass_a, pass_b;
    logic [8:0] lat_a, lat_b;

    ev_t qa[$];
    ev_t qb[$];
    int nchk = 0;
    int npass = 0;

    assign rst_a = rst_n && !sel;
    assign rst_b = rst_n && sel;

    cc_protocol_monitor #(.OUT_BEATS(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .out_valid(out_valid), .out_score(out_score), .exp_valid(exp_valid),
        .exp_score(exp_score), .exp_ready(exp_ready_a), .err(err_a),
        .err_code(code_a), .pass_cnt(pass_a), .last_lat(lat_a)
    );

    cc_protocol_monitor #(.OUT_BEATS(3)) dut_b (
        .clk(clk), .rst_n(rst_b), .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .out_valid(out_valid), .out_score(out_score), .exp_valid(exp_valid),
        .exp_score(exp_score), .exp_ready(exp_ready_b), .err(err_b),
        .err_code(code_b), .pass_cnt(pass_b), .last_lat(lat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic ev_t mk(input int p, input int l, input int e, input int c);
        ev_t r;
        r.pass = 16'(p);
        r.lat  = 9'(l);
        r.err  = 1'(e);
        r.code = 4'(c);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        nchk++;
        if (act == expv) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic cmp_ev(input string nm, input ev_t got, input ev_t expv);
        nchk++;
        if (got == expv) npass++;
        else $display("FAIL %s: got pass=%0d lat=%0d err=%0d code=%0d expected pass=%0d lat=%0d err=%0d code=%0d",
                      nm, got.pass, got.lat, got.err, got.code,
                      expv.pass, expv.lat, expv.err, expv.code);
    endtask

    // Event monitors: sample on negedge, away from the posedge where inputs change.
    logic [15:0] pp_a, pp_b;
    logic        pe_a, pe_b;
    always @(negedge clk) begin
        if (!rst_a) begin
            pp_a = '0; pe_a = 1'b0;
        end else begin
            if (pass_a != pp_a || (err_a && !pe_a)) begin
                if (qa.size() == 0) begin
                    nchk++;
                    $display("FAIL evA: unexpected event pass=%0d err=%0d code=%0d", pass_a, err_a, code_a);
                end else begin
                    cmp_ev("evA", {pass_a, lat_a, err_a, code_a}, qa.pop_front());
                end
            end
            pp_a = pass_a; pe_a = err_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            pp_b = '0; pe_b = 1'b0;
        end else begin
            if (pass_b != pp_b || (err_b && !pe_b)) begin
                if (qb.size() == 0) begin
                    nchk++;
                    $display("FAIL evB: unexpected event pass=%0d err=%0d code=%0d", pass_b, err_b, code_b);
                end else begin
                    cmp_ev("evB", {pass_b, lat_b, err_b, code_b}, qb.pop_front());
                end
            end
            pp_b = pass_b; pe_b = err_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] s);
        exp_valid = 1'b1; exp_score = s;
        step();
        exp_valid = 1'b0; exp_score = '0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_err"},   sel ? int'(err_b)  : int'(err_a),  0);
        chk({tag, "_code"},  sel ? int'(code_b) : int'(code_a), 0);
        chk({tag, "_pass"},  sel ? int'(pass_b) : int'(pass_a), 0);
        chk({tag, "_lat"},   sel ? int'(lat_b)  : int'(lat_a),  0);
        chk({tag, "_ready"}, sel ? int'(exp_ready_b) : int'(exp_ready_a), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // in_valid_1 pulse, in_valid_2 pulse, then one LOAD cycle: next edge is WAIT lat 0.
    task automatic to_wait();
        in_valid_1 = 1'b1; step();
        in_valid_1 = 1'b0; in_valid_2 = 1'b1; step();
        in_valid_2 = 1'b0; step();
    endtask

    task automatic pat(input int lat, input int n, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input bit pv, input logic [6:0] ps);
        to_wait();
        repeat (lat) step();
        for (int i = 0; i < n; i++) begin
            out_valid = 1'b1;
            out_score = (i == 0) ? s0 : (i == 1) ? s1 : s2;
            exp_valid = (i == 0) && pv;
            exp_score = ps;
            step();
            exp_valid = 1'b0; exp_score = '0;
            if (i == 0 && pv) begin
                chk("fifo_cnt_pushpop", int'(dut_a.u_fifo.count_o), 16);
                chk("fifo_ready_pushpop", int'(exp_ready_a), 0);
            end
        end
        out_valid = 1'b0; out_score = '0;
        step();
        step();
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0;
        in_valid_1 = 0; in_valid_2 = 0; out_valid = 0; out_score = '0;
        exp_valid = 0; exp_score = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("rstA");
        rst_n = 1'b1; step(); step();

        // Single-beat passes with different latencies
        push(4); qa.push_back(mk(1, 12, 0, 0)); pat(12, 1, 4, 0, 0, 0, 0);
        push(7); qa.push_back(mk(2, 3, 0, 0));  pat(3, 1, 7, 0, 0, 0, 0);

        // Fill FIFO, drop a push while full, then push+pop on the same beat
        for (int i = 0; i < 16; i++) push(7'(20 + i));
        chk("fifo_full_ready", int'(exp_ready_a), 0);
        exp_valid = 1'b1; exp_score = 7'd99; step(); exp_valid = 1'b0;
        qa.push_back(mk(3, 5, 0, 0)); pat(5, 1, 20, 0, 0, 1, 50);

        // Reset mid-WAIT with a full FIFO: everything back to reset values
        to_wait(); step(); step();
        rst_n = 1'b0; #1;
        rst_chk("rstWait");
        step(); rst_n = 1'b1; step();
        // A stale FIFO head would show up here as a mismatch
        push(4); qa.push_back(mk(1, 2, 0, 0)); pat(2, 1, 4, 0, 0, 0, 0);

        // Pulse too long: pass_cnt stays at 1
        push(6); qa.push_back(mk(1, 1, 1, 3)); pat(1, 2, 6, 6, 0, 0, 0);

        // Nonzero score in first cycle after reset: codes 1 and 5 -> 1
        rst_n = 1'b0; step();
        out_score = 7'd9; rst_n = 1'b1; qa.push_back(mk(0, 0, 1, 1));
        step(); out_score = '0; step(); step();

        // Nonzero score without out_valid
        do_reset();
        out_score = 7'd3; qa.push_back(mk(0, 0, 1, 5));
        step(); out_score = '0; step();

        // out_valid with in_valid_1 high and FIFO empty: codes 6 and 7 -> 6
        do_reset();
        to_wait();
        in_valid_1 = 1'b1; out_valid = 1'b1; out_score = 7'd5; qa.push_back(mk(0, 0, 1, 6));
        step();
        in_valid_1 = 1'b0; out_valid = 1'b0; out_score = '0; step();

        // Latency timeout
        do_reset();
        qa.push_back(mk(0, 0, 1, 2));
        to_wait();
        repeat (520) step();

        // Instance B, OUT_BEATS=3
        sel = 1'b1; rst_n = 1'b0; step();
        rst_chk("rstB");
        rst_n = 1'b1; step();
        push(1); push(2); push(3); qb.push_back(mk(1, 4, 0, 0)); pat(4, 3, 1, 2, 3, 0, 0);
        push(5); push(9); push(0); qb.push_back(mk(1, 2, 1, 8)); pat(2, 3, 5, 9, 1, 0, 0);
        do_reset();
        push(8); push(8); qb.push_back(mk(0, 0, 1, 4)); pat(0, 2, 8, 8, 0, 0, 0);
        step(); step();

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
